// File: rtl/bounce_seq_pkg.sv
// Shared types and constants for the bounce sequencer: FSM state encoding,
// 7-segment glyph table and default parameter values.
package bounce_seq_pkg;

  localparam int NBITS_DEF   = 4;
  localparam int DWELL_DEF   = 2;
  localparam int NBOUNCE_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_UP      = 3'd2,
    ST_HOLD_HI = 3'd3,
    ST_DOWN    = 3'd4,
    ST_HOLD_LO = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  // Segments gfedcba, active high; glyphs 0-9, A, b, C, d, E, F.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [7:0] seg_encode(input logic [3:0] value, input logic dp);
    return {dp, SEG_GLYPH[value]};
  endfunction

endpackage

// File: rtl/bounce_seq_ctrl_updown_cnt.sv
// Loadable up/down counter driven by the bounce sequencer FSM.
module updown_cnt #(
  parameter int NBITS = 4
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic [NBITS-1:0] data,
  output logic [NBITS-1:0] count
);

  logic [NBITS-1:0] r_count;

  // Count register: load has priority over counting.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= data;
    end else if (en) begin
      r_count <= up ? (r_count + NBITS'(1)) : (r_count - NBITS'(1));
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/bounce_seq_ctrl.sv
// Bounce sequencer: sweeps the counter between latched limits with a dwell at
// each end. Define BOUNCE_SEQ_SEG_EN to add the 7-segment output seg[7:0].
module bounce_seq_ctrl
  import bounce_seq_pkg::*;
#(
  parameter int NBITS   = NBITS_DEF,
  parameter int DWELL   = DWELL_DEF,
  parameter int NBOUNCE = NBOUNCE_DEF
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [NBITS-1:0] lo_lim,
  input  logic [NBITS-1:0] hi_lim,
  output logic [NBITS-1:0] count,
  output logic             dir_up,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       state_o
`ifdef BOUNCE_SEQ_SEG_EN
  ,
  output logic [7:0]       seg
`endif
);

  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);
  localparam logic [7:0] BOUNCE_LIM = 8'(NBOUNCE);
  localparam bit         FINITE     = (NBOUNCE != 0);

  state_e           r_state, w_state_nxt;
  logic [3:0]       r_dwell, w_dwell_nxt;
  logic [7:0]       r_bounce, w_bounce_nxt;
  logic [NBITS-1:0] r_lo, w_lo_nxt;
  logic [NBITS-1:0] r_hi, w_hi_nxt;
  logic             r_err, w_err_nxt;
  logic             r_dir_up, w_dir_nxt;
  logic             w_load, w_en, w_up;
  logic             w_running;
  logic [NBITS-1:0] w_count;

  updown_cnt #(.NBITS(NBITS)) u_cnt (
    .clk_2 (clk_2),
    .reset (reset),
    .load  (w_load),
    .en    (w_en),
    .up    (w_up),
    .data  (r_lo),
    .count (w_count)
  );

  assign w_running = (r_state == ST_UP) || (r_state == ST_HOLD_HI) ||
                     (r_state == ST_DOWN) || (r_state == ST_HOLD_LO);

  // State and sequencing registers.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_dwell  <= 4'd0;
      r_bounce <= 8'd0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_err    <= 1'b0;
      r_dir_up <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_dwell  <= w_dwell_nxt;
      r_bounce <= w_bounce_nxt;
      r_lo     <= w_lo_nxt;
      r_hi     <= w_hi_nxt;
      r_err    <= w_err_nxt;
      r_dir_up <= w_dir_nxt;
    end
  end

  // Next-state and counter control; stop beats pause beats normal sequencing.
  always_comb begin
    w_state_nxt  = r_state;
    w_dwell_nxt  = r_dwell;
    w_bounce_nxt = r_bounce;
    w_lo_nxt     = r_lo;
    w_hi_nxt     = r_hi;
    w_err_nxt    = r_err;
    w_dir_nxt    = r_dir_up;
    w_load       = 1'b0;
    w_en         = 1'b0;
    w_up         = 1'b1;
    if (stop) begin
      if (r_state != ST_IDLE) begin
        w_state_nxt = ST_IDLE;
        w_dwell_nxt = 4'd0;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end else if (pause && w_running) begin
      w_state_nxt = r_state;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (lo_lim < hi_lim) begin
              w_lo_nxt     = lo_lim;
              w_hi_nxt     = hi_lim;
              w_err_nxt    = 1'b0;
              w_bounce_nxt = 8'd0;
              w_dwell_nxt  = 4'd0;
              w_state_nxt  = ST_LOAD;
            end else begin
              w_err_nxt = 1'b1;
            end
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_LOAD: begin
          w_load      = 1'b1;
          w_dir_nxt   = 1'b1;
          w_state_nxt = ST_UP;
        end
        ST_UP: begin
          if (w_count == r_hi) begin
            w_state_nxt = ST_HOLD_HI;
          end else begin
            w_en = 1'b1;
          end
        end
        ST_HOLD_HI: begin
          if (r_dwell == DWELL_LAST) begin
            w_dwell_nxt = 4'd0;
            w_en        = 1'b1;
            w_up        = 1'b0;
            w_dir_nxt   = 1'b0;
            w_state_nxt = ST_DOWN;
          end else begin
            w_dwell_nxt = r_dwell + 4'd1;
          end
        end
        ST_DOWN: begin
          if (w_count == r_lo) begin
            w_bounce_nxt = (r_bounce == 8'hFF) ? r_bounce : (r_bounce + 8'd1);
            w_state_nxt  = ST_HOLD_LO;
          end else begin
            w_en = 1'b1;
            w_up = 1'b0;
          end
        end
        ST_HOLD_LO: begin
          if (r_dwell == DWELL_LAST) begin
            w_dwell_nxt = 4'd0;
            if (FINITE && (r_bounce == BOUNCE_LIM)) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_en        = 1'b1;
              w_dir_nxt   = 1'b1;
              w_state_nxt = ST_UP;
            end
          end else begin
            w_dwell_nxt = r_dwell + 4'd1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign count   = w_count;
  assign dir_up  = r_dir_up;
  assign err     = r_err;
  assign busy    = (r_state == ST_LOAD) || w_running;
  assign done    = (r_state == ST_DONE);
  assign state_o = r_state;

`ifdef BOUNCE_SEQ_SEG_EN
  assign seg = seg_encode(4'(w_count), done);
`endif

endmodule

// File: tb/tb_bounce_seq_ctrl.sv
// Scoreboard bench for bounce_seq_ctrl: one instance stops after one round
// trip, a second free-runs; expected count/direction sequences come from a model.
module tb_bounce_seq_ctrl;

  localparam int DWELL = 2;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] lo_lim = 4'd0;
  logic [3:0] hi_lim = 4'd0;

  logic [3:0] count,   f_count;
  logic       dir_up,  f_dir_up;
  logic       busy,    f_busy;
  logic       done,    f_done;
  logic       err,     f_err;
  logic [2:0] state_o, f_state_o;

  int total = 0;
  int bad   = 0;
  logic [4:0] exp_q[$];
  logic [4:0] exp2_q[$];

  always #5 clk_2 = ~clk_2;

  bounce_seq_ctrl #(.NBITS(4), .DWELL(DWELL), .NBOUNCE(1)) u_dut (
    .clk_2(clk_2), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .lo_lim(lo_lim), .hi_lim(hi_lim), .count(count), .dir_up(dir_up),
    .busy(busy), .done(done), .err(err), .state_o(state_o)
  );

  bounce_seq_ctrl #(.NBITS(4), .DWELL(DWELL), .NBOUNCE(0)) u_free (
    .clk_2(clk_2), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .lo_lim(lo_lim), .hi_lim(hi_lim), .count(f_count), .dir_up(f_dir_up),
    .busy(f_busy), .done(f_done), .err(f_err), .state_o(f_state_o)
  );

  // Model: {dir_up, count} per cycle after LOAD for nb round trips.
  task automatic push_sweep(input int lo, input int hi, input int nb);
    for (int b = 0; b < nb; b++) begin
      for (int v = ((b == 0) ? lo : lo + 1); v <= hi; v++) exp_q.push_back({1'b1, 4'(v)});
      for (int d = 0; d < DWELL; d++) exp_q.push_back({1'b1, 4'(hi)});
      for (int v = hi - 1; v >= lo; v--) exp_q.push_back({1'b0, 4'(v)});
      for (int d = 0; d < DWELL; d++) exp_q.push_back({1'b0, 4'(lo)});
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    repeat (2) @(negedge clk_2);
    reset = 1'b0;
  endtask

  task automatic start_run(input logic [3:0] lo, input logic [3:0] hi);
    lo_lim = lo; hi_lim = hi; start = 1'b1;
    @(negedge clk_2);
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({count, dir_up, busy, done, err, state_o} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL reset_state got cnt=%0d dir=%b busy=%b done=%b err=%b st=%0d want 0 1 0 0 0 0",
               count, dir_up, busy, done, err, state_o);
    end
  endtask

  task automatic test_basic_sweep();
    logic [4:0] e;
    do_reset();
    exp_q.delete();
    push_sweep(2, 5, 1);
    start_run(4'd2, 4'd5);
    total++;
    if (state_o !== 3'd1 || busy !== 1'b1) begin
      bad++; $display("FAIL sweep_load got st=%0d busy=%b want 1 1", state_o, busy);
    end
    while (exp_q.size() > 0) begin
      @(negedge clk_2);
      e = exp_q.pop_front();
      total++;
      if ({dir_up, count} !== e) begin
        bad++; $display("FAIL sweep_seq got dir=%b cnt=%0d want dir=%b cnt=%0d", dir_up, count, e[4], e[3:0]);
      end
    end
    @(negedge clk_2);
    total++;
    if ({done, busy, count, state_o} !== {1'b1, 1'b0, 4'd2, 3'd6}) begin
      bad++; $display("FAIL sweep_done got done=%b busy=%b cnt=%0d st=%0d want 1 0 2 6", done, busy, count, state_o);
    end
  endtask

  task automatic test_invalid();
    do_reset();
    start_run(4'd7, 4'd7);
    total++;
    if ({err, state_o, count} !== {1'b1, 3'd0, 4'd0}) begin
      bad++; $display("FAIL invalid_reject got err=%b st=%0d cnt=%0d want 1 0 0", err, state_o, count);
    end
    start_run(4'd1, 4'd3);
    total++;
    if ({err, state_o} !== {1'b0, 3'd1}) begin
      bad++; $display("FAIL invalid_accept got err=%b st=%0d want 0 1", err, state_o);
    end
    @(negedge clk_2);
    total++;
    if ({count, state_o} !== {4'd1, 3'd2}) begin
      bad++; $display("FAIL invalid_load got cnt=%0d st=%0d want 1 2", count, state_o);
    end
  endtask

  task automatic test_pause_stop();
    int hi_cyc;
    do_reset();
    start_run(4'd2, 4'd5);
    repeat (3) @(negedge clk_2);
    total++;
    if ({count, state_o} !== {4'd4, 3'd2}) begin
      bad++; $display("FAIL pause_pre got cnt=%0d st=%0d want 4 2", count, state_o);
    end
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_2);
      total++;
      if ({count, state_o} !== {4'd4, 3'd2}) begin
        bad++; $display("FAIL pause_hold got cnt=%0d st=%0d want 4 2", count, state_o);
      end
    end
    pause = 1'b0;
    @(negedge clk_2);
    total++;
    if (count !== 4'd5) begin
      bad++; $display("FAIL pause_release got cnt=%0d want 5", count);
    end
    hi_cyc = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_2);
      if (count !== 4'd5) break;
      hi_cyc++;
      if (hi_cyc == 2) begin
        total++;
        if (state_o !== 3'd3) begin
          bad++; $display("FAIL hold_state got st=%0d want 3", state_o);
        end
        pause = 1'b1;
      end
      if (hi_cyc == 5) pause = 1'b0;
    end
    pause = 1'b0;
    total++;
    if (hi_cyc != DWELL + 1 + 3 || count !== 4'd4 || state_o !== 3'd4) begin
      bad++; $display("FAIL hold_pause got hi_cycles=%0d cnt=%0d st=%0d want %0d 4 4", hi_cyc, count, state_o, DWELL + 4);
    end
    @(negedge clk_2);
    total++;
    if ({count, state_o, dir_up} !== {4'd3, 3'd4, 1'b0}) begin
      bad++; $display("FAIL stop_pre got cnt=%0d st=%0d dir=%b want 3 4 0", count, state_o, dir_up);
    end
    stop = 1'b1;
    @(negedge clk_2);
    stop = 1'b0;
    total++;
    if ({state_o, count, busy, done} !== {3'd0, 4'd3, 1'b0, 1'b0}) begin
      bad++; $display("FAIL stop_idle got st=%0d cnt=%0d busy=%b done=%b want 0 3 0 0", state_o, count, busy, done);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    start_run(4'd2, 4'd5);
    repeat (3) @(negedge clk_2);
    total++;
    if (count !== 4'd4) begin
      bad++; $display("FAIL areset_pre got cnt=%0d want 4", count);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({count, state_o, busy, dir_up} !== {4'd0, 3'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL areset_now got cnt=%0d st=%0d busy=%b dir=%b want 0 0 0 1", count, state_o, busy, dir_up);
    end
    @(negedge clk_2);
    reset = 1'b0;
  endtask

  task automatic test_free_run_restart();
    logic [4:0] e;
    do_reset();
    exp_q.delete();
    push_sweep(0, 15, 4);
    exp2_q = exp_q;
    exp_q.delete();
    start_run(4'd0, 4'd15);
    for (int i = 0; i < 102; i++) begin
      if (i == 100) begin
        total++;
        if ({done, busy, count, state_o} !== {1'b1, 1'b0, 4'd0, 3'd6}) begin
          bad++; $display("FAIL free_dut1_done got done=%b busy=%b cnt=%0d st=%0d want 1 0 0 6", done, busy, count, state_o);
        end
        lo_lim = 4'd4; hi_lim = 4'd9; start = 1'b1;
      end
      @(negedge clk_2);
      start = 1'b0;
      if (exp2_q.size() == 0) begin
        total++; bad++; $display("FAIL free_queue empty at cycle %0d want entry", i);
      end else begin
        e = exp2_q.pop_front();
        total++;
        if ({f_busy, f_done, f_dir_up, f_count} !== {1'b1, 1'b0, e}) begin
          bad++; $display("FAIL free_seq cyc=%0d got busy=%b done=%b dir=%b cnt=%0d want 1 0 %b %0d",
                          i, f_busy, f_done, f_dir_up, f_count, e[4], e[3:0]);
        end
      end
      if (i == 100) begin
        total++;
        if ({state_o, done} !== {3'd1, 1'b0}) begin
          bad++; $display("FAIL restart_load got st=%0d done=%b want 1 0", state_o, done);
        end
      end
      if (i == 101) begin
        total++;
        if ({count, state_o, dir_up} !== {4'd4, 3'd2, 1'b1}) begin
          bad++; $display("FAIL restart_count got cnt=%0d st=%0d dir=%b want 4 2 1", count, state_o, dir_up);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_invalid();
    test_pause_stop();
    test_async_reset();
    test_free_run_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bounce_seq_ctrl.md
Name: bounce_seq_ctrl

Overview:
- Sequencer for the 4-bit loadable up/down counter. Drives load, enable and direction so the count sweeps back and forth between two latched limits, with a programmable dwell at each end.
- Stops after a set number of round trips, or runs indefinitely.
- Sits between the SWI switch panel and the LED/7-segment outputs in top; replaces manual load/count_up/counter_on switching.

Parameters:
- NBITS, 4, counter and limit width.
- DWELL, 2, cycles held at each limit (legal range 1..15).
- NBOUNCE, 3, round trips before DONE; 0 means run forever.

Ports:
- clk_2  in  1  system clock (divided board clock).
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level, sampled each edge; begins or restarts a run from IDLE/DONE.
- stop  in  1  level; abort to IDLE.
- pause  in  1  level; freezes a run in progress.
- lo_lim  in  NBITS  lower limit, latched on accepted start.
- hi_lim  in  NBITS  upper limit, latched on accepted start.
- count  out  NBITS  current counter value.
- dir_up  out  1  1 = ascending phase.
- busy  out  1  high in LOAD/UP/HOLD_HI/DOWN/HOLD_LO.
- done  out  1  high in DONE.
- err  out  1  high after a start was rejected for invalid limits.
- state_o  out  3  encoded FSM state, for LED debug.

Behaviour:
- Reset: state IDLE, count 0, dir_up 1, busy 0, done 0, err 0, bounce counter 0, dwell counter 0. Applies immediately and asynchronously, including mid-run.
- Priority each edge: reset > stop > pause > normal.
- All outputs are registered or decoded from registered state; no combinational path from any input to any output.
- IDLE, start=1:
  - lo_lim < hi_lim: latch limits, clear err and bounce counter, go LOAD.
  - Otherwise: set err=1 and stay IDLE.
- DONE, start=1: same check as IDLE; done clears on leaving DONE.
- LOAD (1 cycle): count <= lo, dir_up <= 1, go UP.
- UP:
  - count == hi: go HOLD_HI, count unchanged.
  - Otherwise: count <= count+1.
- HOLD_HI: dwell counter increments each cycle. On the DWELL-th cycle: count <= count-1, dir_up <= 0, go DOWN.
- DOWN:
  - count == lo: increment bounce counter, go HOLD_LO.
  - Otherwise: count <= count-1.
- HOLD_LO: dwell for DWELL cycles, then:
  - NBOUNCE != 0 and bounces == NBOUNCE: go DONE, count holds at lo.
  - Otherwise: count <= count+1, dir_up <= 1, go UP.
- Endpoint timing: hi is visible DWELL+1 cycles per peak; lo is visible DWELL+1 cycles per trough (LOAD entry excluded).
- Wrap-around can never occur: lo < hi is enforced and the count stays in [lo,hi].
- pause=1 in UP/HOLD_HI/DOWN/HOLD_LO: state, count and dwell counter frozen. Ignored in IDLE/LOAD/DONE.
- stop=1 in any state except IDLE: go IDLE next edge, count holds its last value, busy=0, done=0.
- Limit inputs changing mid-run have no effect.
- Bounce counter is 8 bits; with NBOUNCE=0 it saturates at 255.

Optional Feature:
- Macro BOUNCE_SEQ_SEG_EN defined:
  - Adds output seg[7:0], the 7-segment pattern of count (0-9, A-F, same glyphs as the display table).
  - seg[7] (decimal point) = done.
  - Reset value 8'b00111111.
- Macro undefined: no seg port; top decodes count itself.

Decomposition:
- Package bounce_seq_pkg:
  - state enum: IDLE, LOAD, UP, HOLD_HI, DOWN, HOLD_LO, DONE.
  - 16-entry 7-segment glyph constant array.
  - default parameter constants.
- Sub-module updown_cnt: NBITS counter with asynchronous active-high reset and inputs load, data, en, up. The FSM drives it; count comes from it.

Test Plan:
- Basic sweep: lo=2, hi=5, DWELL=2, NBOUNCE=1, start pulse -> count 2,3,4,5,5,5,4,3,2,2,2, then done=1 with count=2, busy=0.
- Invalid limits: lo=7, hi=7, start -> err=1, stays IDLE, count unchanged. Then lo=1, hi=3, start -> err=0, LOAD, count=1.
- Pause: pause=1 for 4 cycles while count=4 in UP -> count stays 4 and state stays UP; after release, next value is 5.
- Pause at endpoint: pause during HOLD_HI -> dwell does not advance; hi is visible DWELL+1 cycles plus the paused cycles.
- Stop and reset mid-run:
  - stop while count=3 in DOWN -> IDLE next edge, count=3, busy=0.
  - Async reset between edges -> count=0, state IDLE immediately.
- Free-run and restart: NBOUNCE=0, lo=0, hi=15 -> count never exceeds 15 or drops below 0 over 100 cycles. Start from DONE with new limits 4/9 -> count reloads to 4.
